sqrt_share_sched: RTL and testbench
===================================

// Module: sqrt_share_sched
// PURPOSE
//   Shares one iterative square-root datapath among N_REQ requesters.
//   - Round-robin arbiter accepts one operand per job over a valid/ready handshake.
//   - Sequences the bit-serial sqrt core, then returns root, remainder and requester ID.
//   - Sits between the pin-level input muxing and the shared sqrt unit; requesters with
//     7-bit operands from io_in[7:1] zero-extend into WIDTH.
// PARAMETERS
//   N_REQ  4  number of requesters (>=2)
//   WIDTH  8  operand width; must be even; root is WIDTH/2 bits, remainder WIDTH/2+1 bits
// PORTS
//   clk        in   1              single clock, rising edge
//   rst        in   1              asynchronous, active-high reset
//   req_valid  in   N_REQ          requester i has an operand pending
//   req_data   in   N_REQ*WIDTH    operand i at [i*WIDTH +: WIDTH]
//   req_ready  out  N_REQ          one-hot accept strobe; operand i sampled on this edge
//   rsp_valid  out  1              result available
//   rsp_ready  in   1              consumer accepts result
//   rsp_id     out  $clog2(N_REQ)  index of the requester that owns the result
//   rsp_root   out  WIDTH/2        floor(sqrt(operand))
//   rsp_rem    out  WIDTH/2+1      operand - root*root
//   busy       out  1              high whenever state != IDLE
// BEHAVIOUR
//   - Reset (async assert): state IDLE, RR pointer 0. All outputs 0: rsp_valid, rsp_id,
//     rsp_root, rsp_rem, busy, req_ready.
//   - FSM IDLE -> ITER -> DONE -> IDLE.
//     - IDLE: if any req_valid, grant the first valid index at or after the pointer,
//       searching upward with wrap. req_ready[g]=1 combinationally that cycle.
//       On the edge: capture operand g and id g, start the core, pointer <= (g+1) mod N_REQ,
//       go to ITER. No valid: stay in IDLE, req_ready=0.
//     - ITER: the core resolves one root bit per cycle, MSB first, digit-by-digit
//       (two operand bits per step). A counter runs WIDTH/2 edges; the last edge loads
//       rsp_* and enters DONE. req_ready=0.
//     - DONE: rsp_valid=1. rsp_id, rsp_root and rsp_rem are registered and held stable.
//       On rsp_valid&&rsp_ready, go to IDLE. req_ready=0.
//   - Latency: rsp_valid rises exactly WIDTH/2 edges after the accepting edge (4 by default).
//     Minimum job-to-job spacing is WIDTH/2+2 cycles.
//   - req_ready is never asserted outside IDLE. At most one bit is set per cycle.
//   - A requester may drop req_valid before it is granted; this causes no side effects.
//     req_data is sampled only on the grant edge.
//   - Backpressure: while in DONE with rsp_ready=0, all outputs are frozen indefinitely.
//     Pending requests wait.
//   - Pointer wrap: grant to N_REQ-1 sets the pointer to 0.
//     Simultaneous requests are served in RR order from the pointer.
//   - Reset mid-job: the job is abandoned with no response, and every output reads 0 at once.
//     After release, the first grant goes to the lowest valid index.
//   - Arithmetic is unsigned. The core's internal remainder is WIDTH/2+2 bits, signed, to
//     hold the trial-subtract sign. rsp_rem is never negative and is <= 2*rsp_root.
// STRUCTURE
//   - sqrt_pkg: sched_state_e {IDLE,ITER,DONE} typedef; a function root_w(WIDTH)=WIDTH/2.
//   - Sub-module sqrt_iter_core (clk, rst, start, operand, done, root, rem): the bit-serial
//     datapath.
//   - This block holds the arbiter, pointer, FSM, iteration counter and response registers.
// TESTING
//   1. Single job: req_valid[0]=1, data 32 -> req_ready[0] pulses once.
//      rsp_valid 4 edges later with id 0, root 5, rem 7.
//   2. Values on req 1: 0 -> root 0, rem 0; 127 -> root 11, rem 6; 255 -> root 15, rem 30;
//      1 -> root 1, rem 0.
//   3. After reset, all four valid together with 16/36/64/100, rsp_ready=1 ->
//      ids 0,1,2,3 in order with roots 4,6,8,10, all rem 0.
//   4. Fairness: req0 and req2 held valid continuously -> grants alternate 0,2,0,2.
//      Req1 raised later is served before req2's next turn when the pointer is 1.
//   5. Backpressure: rsp_ready=0 for 10 cycles in DONE -> rsp_* stable, req_ready stays 0,
//      busy=1. rsp_ready=1 -> IDLE next, then a new grant the following cycle.
//   6. Assert rst during ITER -> all outputs 0 immediately, no rsp_valid.
//      After release with req3 and req1 valid -> first grant to req1.

Source files
------------

// File: rtl/sqrt_pkg.sv
// Shared types and helpers for the shared square-root scheduler.
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } sched_state_e;

    // Root width for an operand of width w (w must be even).
    function automatic int unsigned root_w(input int unsigned w);
        return w / 2;
    endfunction

endpackage

// File: rtl/sqrt_iter_core.sv
// Bit-serial digit-by-digit square root: one root bit per cycle, MSB first,
// consuming two operand bits per step.
module sqrt_iter_core
    import sqrt_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   operand,
    output logic               done,
    output logic [WIDTH/2-1:0] root,
    output logic [WIDTH/2:0]   rem
);

    localparam int unsigned RW  = root_w(WIDTH);
    localparam int unsigned RMW = RW + 2;
    localparam int unsigned SW  = RW + 4;
    localparam int unsigned CW  = (RW > 1) ? $clog2(RW) : 1;
    localparam logic [CW-1:0] LAST = CW'(RW - 1);

    logic [WIDTH-1:0]      r_x;
    logic [RW-1:0]         r_root;
    logic signed [RMW-1:0] r_rem;
    logic [CW-1:0]         r_step;
    logic                  r_active;

    logic signed [SW-1:0]  w_shift;
    logic signed [SW-1:0]  w_trial;
    logic                  w_neg;
    logic [RW-1:0]         w_root_nxt;
    logic signed [RMW-1:0] w_rem_nxt;

    // One trial-subtract step; root/rem expose the post-step values so the
    // scheduler can capture the final result on the same edge as the last step.
    always_comb begin
        w_shift    = {r_rem, r_x[WIDTH-1 -: 2]};
        w_trial    = w_shift - $signed({2'b00, r_root, 2'b01});
        w_neg      = w_trial[SW-1];
        w_root_nxt = {r_root[RW-2:0], ~w_neg};
        w_rem_nxt  = w_neg ? RMW'(w_shift) : RMW'(w_trial);
    end

    assign done = r_active && (r_step == LAST);
    assign root = w_root_nxt;
    assign rem  = w_rem_nxt[RW:0];

    // Load operand on start, then iterate until the last root bit resolves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x      <= '0;
            r_root   <= '0;
            r_rem    <= '0;
            r_step   <= '0;
            r_active <= 1'b0;
        end else if (start) begin
            r_x      <= operand;
            r_root   <= '0;
            r_rem    <= '0;
            r_step   <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            r_x      <= {r_x[WIDTH-3:0], 2'b00};
            r_root   <= w_root_nxt;
            r_rem    <= w_rem_nxt;
            r_step   <= r_step + 1'b1;
            if (done) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sqrt_share_sched.sv
// Round-robin scheduler sharing one iterative sqrt core among N_REQ requesters.
module sqrt_share_sched
    import sqrt_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [WIDTH/2-1:0]       rsp_root,
    output logic [WIDTH/2:0]         rsp_rem,
    output logic                     busy
);

    localparam int unsigned RW = root_w(WIDTH);
    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned CW = (RW > 1) ? $clog2(RW) : 1;
    localparam logic [CW-1:0] LAST    = CW'(RW - 1);
    localparam logic [IW-1:0] TOP_IDX = IW'(N_REQ - 1);

    sched_state_e r_state;
    sched_state_e w_state_nxt;

    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_job_id;
    logic [CW-1:0]    r_cnt;
    logic [IW-1:0]    r_rsp_id;
    logic [RW-1:0]    r_rsp_root;
    logic [RW:0]      r_rsp_rem;

    logic             w_any;
    logic [IW-1:0]    w_gidx;
    logic [IW-1:0]    w_k;
    logic             w_start;
    logic             w_last;
    logic [WIDTH-1:0] w_operand;
    logic             w_core_done;
    logic [RW-1:0]    w_core_root;
    logic [RW:0]      w_core_rem;

    // Round-robin search: first valid index at or after the pointer, with wrap.
    always_comb begin
        w_any  = 1'b0;
        w_gidx = '0;
        w_k    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_k = IW'((r_ptr + i) % N_REQ);
            if (!w_any && req_valid[w_k]) begin
                w_any  = 1'b1;
                w_gidx = w_k;
            end
        end
    end

    // Select the granted requester's operand.
    always_comb begin
        w_operand = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (IW'(i) == w_gidx) begin
                w_operand = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_start = (r_state == IDLE) && w_any && !rst;
    assign w_last  = (r_state == ITER) && (r_cnt == LAST) && w_core_done;

    // One-hot accept strobe, only while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if (w_start) begin
            req_ready[w_gidx] = 1'b1;
        end
    end

    // Next-state logic for IDLE -> ITER -> DONE -> IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start)   w_state_nxt = ITER;
            ITER:    if (w_last)    w_state_nxt = DONE;
            DONE:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pointer, iteration counter, job id and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= '0;
            r_job_id   <= '0;
            r_cnt      <= '0;
            r_rsp_id   <= '0;
            r_rsp_root <= '0;
            r_rsp_rem  <= '0;
        end else begin
            if (w_start) begin
                r_ptr    <= (w_gidx == TOP_IDX) ? '0 : w_gidx + 1'b1;
                r_job_id <= w_gidx;
                r_cnt    <= '0;
            end else if (r_state == ITER) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_last) begin
                r_rsp_id   <= r_job_id;
                r_rsp_root <= w_core_root;
                r_rsp_rem  <= w_core_rem;
            end
        end
    end

    sqrt_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .start   (w_start),
        .operand (w_operand),
        .done    (w_core_done),
        .root    (w_core_root),
        .rem     (w_core_rem)
    );

    assign rsp_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign rsp_id    = r_rsp_id;
    assign rsp_root  = r_rsp_root;
    assign rsp_rem   = r_rsp_rem;

endmodule

// File: tb/tb_sqrt_share_sched.sv
// Self-checking bench for sqrt_share_sched: directed scenarios plus random
// traffic compared every cycle against a job-level behavioural model.
module tb_sqrt_share_sched;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int RW = W / 2;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*W-1:0]  req_data;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [RW-1:0]   rsp_root;
    logic [RW:0]     rsp_rem;
    logic            busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: one job in flight at most; m_age counts edges since acceptance.
    int m_ptr = 0;
    bit m_job = 1'b0;
    int m_age = 0;
    int m_id  = 0;
    int m_op  = 0;

    always #5 clk = ~clk;

    sqrt_share_sched #(
        .N_REQ (N),
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_root  (rsp_root),
        .rsp_rem   (rsp_rem),
        .busy      (busy)
    );

    function automatic int isqrt(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    function automatic int pick(input int ptr, input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_job = 1'b0;
        m_ptr = 0;
        m_age = 0;
    endtask

    task automatic model_edge();
        int g;
        if (rst) begin
            model_reset();
        end else if (!m_job) begin
            g = pick(m_ptr, req_valid);
            if (g >= 0) begin
                m_job = 1'b1;
                m_age = 0;
                m_id  = g;
                m_op  = int'(req_data[g*W +: W]);
                m_ptr = (g + 1) % N;
            end
        end else if (m_age < RW) begin
            m_age++;
        end else if (rsp_ready) begin
            m_job = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        #1 rst = 1'b0;
    endtask

    task automatic wait_rsp(input string name, output int n);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 30) begin
            tick();
            n++;
            @(negedge clk);
        end
        chk({name, "_timeout"}, rsp_valid, 1);
    endtask

    task automatic run_job(input int idx, input int val, input int er, input int em);
        int n;
        req_valid = '0;
        req_valid[idx] = 1'b1;
        req_data[idx*W +: W] = W'(val);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("job_strobe", req_ready, 1 << idx);
        tick();
        req_valid = '0;
        wait_rsp("job", n);
        chk("job_latency", n, RW);
        chk("job_id", rsp_id, idx);
        chk("job_root", rsp_root, er);
        chk("job_rem", rsp_rem, em);
        tick();
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            int g;
            int r;
            logic [N-1:0] er;
            g  = m_job ? -1 : pick(m_ptr, req_valid);
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            chk("req_ready", req_ready, er);
            chk("busy", busy, m_job);
            chk("rsp_valid", rsp_valid, m_job && (m_age == RW));
            if (m_job && (m_age == RW)) begin
                r = isqrt(m_op);
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_root", rsp_root, r);
                chk("rsp_rem", rsp_rem, m_op - r * r);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int got;
        int ng;
        int grants[5];
        int exp_grants[5];
        int roots[4];
        logic [N-1:0] gr;

        exp_grants = '{0, 2, 0, 1, 2};
        roots      = '{4, 6, 8, 10};

        rst       = 1'b1;
        req_valid = '1;
        req_data  = '0;
        rsp_ready = 1'b0;
        #3;
        chk("reset_req_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_rsp_root", rsp_root, 0);
        chk("reset_rsp_rem", rsp_rem, 0);
        req_valid = '0;
        chk_en = 1'b1;
        tick();
        tick();
        #1 rst = 1'b0;

        chk("model_isqrt_127", isqrt(127), 11);
        chk("model_isqrt_255", isqrt(255), 15);
        chk("model_pick_wrap", pick(3, 4'b1010), 3);
        chk("model_pick_low", pick(2, 4'b0011), 0);

        // Single job and value sweep on requester 1.
        run_job(0, 32, 5, 7);
        run_job(1, 0, 0, 0);
        run_job(1, 127, 11, 6);
        run_job(1, 255, 15, 30);
        run_job(1, 1, 1, 0);

        // All four valid together after reset.
        do_reset();
        req_data  = {8'd100, 8'd64, 8'd36, 8'd16};
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 100 && got < 4; c++) begin
            @(negedge clk);
            gr = req_ready;
            if (rsp_valid) begin
                chk("all4_id", rsp_id, got);
                chk("all4_root", rsp_root, roots[got]);
                chk("all4_rem", rsp_rem, 0);
                got++;
            end
            tick();
            req_valid = req_valid & ~gr;
        end
        chk("all4_count", got, 4);

        // Fairness between req0 and req2, req1 raised when the pointer is 1.
        do_reset();
        req_data  = $urandom;
        req_valid = 4'b0101;
        rsp_ready = 1'b1;
        ng = 0;
        for (int c = 0; c < 200 && ng < 5; c++) begin
            @(negedge clk);
            gr = req_ready;
            tick();
            if (gr != '0) begin
                grants[ng] = onehot_idx(gr);
                ng++;
                if (ng == 3) req_valid[1] = 1'b1;
                if (grants[ng-1] == 1) req_valid[1] = 1'b0;
            end
        end
        chk("fair_count", ng, 5);
        for (int i = 0; i < ng; i++) begin
            chk("fair_grant", grants[i], exp_grants[i]);
        end
        req_valid = '0;
        wait_rsp("fair_drain", n);
        tick();

        // Backpressure in DONE.
        do_reset();
        req_data  = {8'd0, 8'd81, 8'd0, 8'd200};
        req_valid = 4'b0101;
        rsp_ready = 1'b0;
        tick();
        wait_rsp("bp", n);
        for (int c = 0; c < 10; c++) begin
            chk("bp_root", rsp_root, 14);
            chk("bp_rem", rsp_rem, 4);
            chk("bp_id", rsp_id, 0);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_busy", busy, 1);
            tick();
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("bp_idle", busy, 0);
        chk("bp_next_grant", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        wait_rsp("bp_second", n);
        chk("bp_second_id", rsp_id, 2);
        chk("bp_second_root", rsp_root, 9);
        chk("bp_second_rem", rsp_rem, 0);
        tick();

        // Reset during ITER.
        do_reset();
        req_data  = {8'd49, 8'd0, 8'd9, 8'd50};
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        #2;
        rst = 1'b1;
        req_valid = 4'b1010;
        model_reset();
        #1;
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rsp_id", rsp_id, 0);
        chk("midrst_rsp_root", rsp_root, 0);
        chk("midrst_rsp_rem", rsp_rem, 0);
        tick();
        tick();
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_first_grant", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        wait_rsp("midrst_job", n);
        chk("midrst_job_id", rsp_id, 1);
        chk("midrst_job_root", rsp_root, 3);
        tick();

        // Random traffic against the model, with one asynchronous reset.
        for (int c = 0; c < 3000; c++) begin
            tick();
            req_valid = N'($urandom_range(0, 15));
            req_data  = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (c == 1500) begin
                #2 rst = 1'b1;
                model_reset();
                tick();
                #1 rst = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
